// File: rtl/csidh_io_pkg.sv
// Shared types and sizing helpers for the CSIDH streaming host interface.
package csidh_io_pkg;

  typedef enum logic [2:0] {
    ST_LOAD_A,
    ST_LOAD_K,
    ST_START,
    ST_RUN,
    ST_DRAIN
  } state_t;

  function automatic int unsigned ceil_div(input int unsigned a, input int unsigned b);
    return (a + b - 1) / b;
  endfunction

  function automatic int unsigned clog2(input int unsigned x);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(x)) r = r + 1;
    return r;
  endfunction

  function automatic int unsigned umax(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // Counter width that never collapses to zero bits.
  function automatic int unsigned cnt_w(input int unsigned x);
    return (clog2(x) == 0) ? 1 : clog2(x);
  endfunction

endpackage

// File: rtl/csidh_word_ser.sv
// Output serialiser: captures an N-bit result and emits it as WA little-endian
// BUS_W-bit words on a valid/ready stream, zero-padding past bit N.
module csidh_word_ser import csidh_io_pkg::*; #(
  parameter int unsigned N     = 512,
  parameter int unsigned BUS_W = 64,
  parameter int unsigned WA    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             capture,
  input  logic [N-1:0]     cap_data,
  input  logic             out_ready,
  output logic [BUS_W-1:0] out_data,
  output logic             out_valid,
  output logic             out_last,
  output logic             done
);

  localparam int unsigned SW     = WA * BUS_W;
  localparam int unsigned KW     = cnt_w(WA);
  localparam int unsigned PENULT = (WA > 1) ? WA - 2 : 0;

  logic [SW-1:0] cap_q;
  logic [KW-1:0] k_q;

  assign out_data = cap_q[BUS_W-1:0];

  // Shift register drains one word per handshake; zeros fill in from the top.
  always_ff @(posedge clk) begin
    if (rst) begin
      cap_q     <= '0;
      k_q       <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (capture) begin
        cap_q     <= SW'(cap_data);
        k_q       <= '0;
        out_valid <= 1'b1;
        out_last  <= (WA == 1);
      end else if (out_valid && out_ready) begin
        cap_q    <= cap_q >> BUS_W;
        k_q      <= k_q + KW'(1);
        out_last <= (k_q == KW'(PENULT));
        if (out_last) begin
          k_q       <= '0;
          out_valid <= 1'b0;
          out_last  <= 1'b0;
          done      <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/csidh_stream_io.sv
// Streaming host interface for the CSIDH core: loads A and the key from the
// input stream, sequences the core, and streams the result (or zeros on error).
module csidh_stream_io import csidh_io_pkg::*; #(
  parameter int unsigned N       = 512,
  parameter int unsigned BUS_W   = 64,
  parameter int unsigned KEY_W   = 296,
  parameter int unsigned TIMEOUT = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [BUS_W-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [BUS_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic             done,
  output logic             busy,
  output logic             error,
  output logic             core_rst,
  output logic [N-1:0]     core_A,
  output logic [KEY_W-1:0] core_key,
  input  logic             core_done,
  input  logic [N-1:0]     core_A_out,
  input  logic             core_invalid
);

  localparam int unsigned WA     = ceil_div(N, BUS_W);
  localparam int unsigned WK     = ceil_div(KEY_W, BUS_W);
  localparam int unsigned CW     = cnt_w(umax(WA, WK));
  localparam int unsigned TW     = cnt_w(TIMEOUT);
  localparam int unsigned TO_LIM = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;

  state_t        state_q, state_d;
  logic [CW-1:0] wcnt_q;
  logic [TW-1:0] run_cnt_q;
  logic          a_we, k_we, a_last, k_last;
  logic          timeout, capture, cap_err, drain_end;

  assign a_we      = in_valid && in_ready && (state_q == ST_LOAD_A);
  assign k_we      = in_valid && in_ready && (state_q == ST_LOAD_K);
  assign a_last    = (wcnt_q == CW'(WA - 1));
  assign k_last    = (wcnt_q == CW'(WK - 1));
  assign timeout   = (TIMEOUT != 0) && (run_cnt_q == TW'(TO_LIM));
  assign capture   = (state_q == ST_RUN) && (core_done || timeout);
  assign cap_err   = core_done ? core_invalid : 1'b1;
  assign drain_end = out_valid && out_ready && out_last;

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_LOAD_A;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_LOAD_A: if (a_we && a_last) state_d = ST_LOAD_K;
      ST_LOAD_K: if (k_we && k_last) state_d = ST_START;
      ST_START:  state_d = ST_RUN;
      ST_RUN:    if (capture) state_d = ST_DRAIN;
      ST_DRAIN:  if (drain_end) state_d = ST_LOAD_A;
      default:   state_d = ST_LOAD_A;
    endcase
  end

  // Handshake/control outputs are registered from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_ready  <= 1'b0;
      busy      <= 1'b0;
      core_rst  <= 1'b1;
      error     <= 1'b0;
      wcnt_q    <= '0;
      run_cnt_q <= '0;
      core_A    <= '0;
      core_key  <= '0;
    end else begin
      in_ready  <= (state_d == ST_LOAD_A) || (state_d == ST_LOAD_K);
      busy      <= (state_d == ST_START) || (state_d == ST_RUN) || (state_d == ST_DRAIN);
      core_rst  <= (state_d != ST_RUN);
      run_cnt_q <= (state_q == ST_RUN) ? run_cnt_q + TW'(1) : '0;

      if (a_we || k_we)
        wcnt_q <= ((a_we && a_last) || (k_we && k_last)) ? '0 : wcnt_q + CW'(1);

      if (a_we && (wcnt_q == '0)) error <= 1'b0;
      else if (capture && cap_err) error <= 1'b1;

      // Word i lands at bits [BUS_W*i +: BUS_W]; bits past the operand width drop.
      for (int j = 0; j < N; j++)
        if (a_we && (wcnt_q == CW'(j / BUS_W))) core_A[j] <= in_data[j % BUS_W];
      for (int j = 0; j < KEY_W; j++)
        if (k_we && (wcnt_q == CW'(j / BUS_W))) core_key[j] <= in_data[j % BUS_W];
    end
  end

  csidh_word_ser #(
    .N     (N),
    .BUS_W (BUS_W),
    .WA    (WA)
  ) u_ser (
    .clk       (clk),
    .rst       (rst),
    .capture   (capture),
    .cap_data  (cap_err ? '0 : core_A_out),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_last  (out_last),
    .done      (done)
  );

endmodule

// File: tb/tb_csidh_stream_io.sv
// Bench for csidh_stream_io: table of transactions against a stub core, plus
// reset-abort and 48-bit-bus padding sequences.
module tb_csidh_stream_io;

  localparam int unsigned N = 512, BW = 64, KW = 296, TO = 1000, LAT = 100;
  localparam int WA = 8, WK = 5;
  localparam int M_OK = 0, M_INV = 1, M_HANG = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, in_valid, in_ready, out_valid, out_ready, out_last, done, busy, error;
  logic          core_rst, core_done, core_invalid;
  logic [BW-1:0] in_data, out_data;
  logic [N-1:0]  core_A, core_A_out;
  logic [KW-1:0] core_key;

  csidh_stream_io #(.N(N), .BUS_W(BW), .KEY_W(KW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .done(done), .busy(busy), .error(error), .core_rst(core_rst), .core_A(core_A),
    .core_key(core_key), .core_done(core_done), .core_A_out(core_A_out),
    .core_invalid(core_invalid)
  );

  // Stub core: result A+1, done LAT cycles after core_rst drops.
  int stub_mode, stub_cnt;
  always @(posedge clk) stub_cnt <= core_rst ? 0 : stub_cnt + 1;
  assign core_done    = !core_rst && (stub_mode != M_HANG) && (stub_cnt == int'(LAT) - 1);
  assign core_A_out   = core_A + 512'd1;
  assign core_invalid = (stub_mode == M_INV);

  // Second instance on a 48-bit bus with an echo core.
  logic          in_valid48, in_ready48, out_valid48, out_ready48, out_last48, done48;
  logic          busy48, error48, core_rst48, core_done48;
  logic [47:0]   in_data48, out_data48;
  logic [N-1:0]  core_A48;
  logic [KW-1:0] core_key48;
  int            cnt48;

  csidh_stream_io #(.N(N), .BUS_W(48), .KEY_W(KW), .TIMEOUT(0)) dut48 (
    .clk(clk), .rst(rst), .in_data(in_data48), .in_valid(in_valid48), .in_ready(in_ready48),
    .out_data(out_data48), .out_valid(out_valid48), .out_ready(out_ready48),
    .out_last(out_last48), .done(done48), .busy(busy48), .error(error48),
    .core_rst(core_rst48), .core_A(core_A48), .core_key(core_key48),
    .core_done(core_done48), .core_A_out(core_A48), .core_invalid(1'b0)
  );
  always @(posedge clk) cnt48 <= core_rst48 ? 0 : cnt48 + 1;
  assign core_done48 = !core_rst48 && (cnt48 == 4);

  int n_checks = 0, n_fail = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_b(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0b expected %0b", name, act, exp);
    end
  endtask

  task automatic chk_v(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0][63:0] a;
    logic [4:0][63:0] k;
    int               mode;
    bit               gaps;
    int               abort_at;
    logic [511:0]     exp_a;
    logic [295:0]     exp_key;
    logic [7:0][63:0] exp_out;
    bit               exp_err;
    int               exp_run;
    bit               err_before;
  } txn_t;

  txn_t tbl [9];

  // Reference model: operands are the concatenated words; result is A+1 or zeros.
  function automatic txn_t mk(input int mode, input bit gaps, input int abort_at,
                              input logic [7:0][63:0] a, input logic [4:0][63:0] k);
    txn_t t;
    logic [319:0] kf;
    t.a = a; t.k = k; t.mode = mode; t.gaps = gaps; t.abort_at = abort_at;
    kf = k;
    t.exp_a   = a;
    t.exp_key = kf[295:0];
    t.exp_err = (mode != M_OK);
    t.exp_run = (mode == M_HANG) ? int'(TO) : int'(LAT);
    t.exp_out = (mode == M_OK) ? t.exp_a + 512'd1 : 512'd0;
    t.err_before = 1'b0;
    return t;
  endfunction

  function automatic logic [7:0][63:0] rnd_a();
    logic [7:0][63:0] a;
    for (int w = 0; w < 8; w++) a[w] = {$urandom, $urandom};
    return a;
  endfunction

  function automatic logic [4:0][63:0] rnd_k();
    logic [4:0][63:0] k;
    for (int w = 0; w < 5; w++) k[w] = {$urandom, $urandom};
    return k;
  endfunction

  task automatic run_txn(input txn_t t);
    int acc, guard, run, idx;
    bit fire, hs;
    stub_mode = t.mode;
    chk_b("err_hold", error, t.err_before);
    acc = 0; guard = 0;
    while (acc < WA + WK && guard < 2000) begin
      in_valid = t.gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      in_data  = (acc < WA) ? t.a[acc] : t.k[acc - WA];
      if (!in_valid) in_data = {$urandom, $urandom};
      fire = in_valid && in_ready;
      tick(); guard++;
      if (fire) begin
        acc++;
        if (acc == 1) chk_b("err_clear", error, 1'b0);
      end
    end
    in_valid = 1'b0;
    chk_b("load_bound", guard < 2000, 1'b1);
    chk_b("start_core_rst", core_rst, 1'b1);
    chk_b("start_busy", busy, 1'b1);
    chk_b("start_in_ready", in_ready, 1'b0);
    chk_v("core_A", core_A, t.exp_a);
    chk_v("core_key", 512'(core_key), 512'(t.exp_key));
    if (t.k[4] == 64'hFFFF_FFFF_FFFF_FFFF)
      chk_v("key_top", 512'(core_key[295:256]), 512'(40'hFF_FFFF_FFFF));
    tick();
    run = 0;
    while (core_rst == 1'b0 && run < 5000) begin
      run++;
      tick();
    end
    chk_v("run_len", 512'(run), 512'(t.exp_run));
    chk_b("drain_valid", out_valid, 1'b1);
    chk_b("drain_error", error, t.exp_err);
    idx = 0; guard = 0; out_ready = 1'b0;
    while (idx < WA && guard < 400) begin
      out_ready = t.gaps ? ~out_ready : 1'b1;
      hs = out_valid && out_ready;
      if (hs) begin
        chk_v($sformatf("out_word%0d", idx), 512'(out_data), 512'(t.exp_out[idx]));
        chk_b($sformatf("out_last%0d", idx), out_last, idx == WA - 1);
      end
      tick(); guard++;
      if (hs) begin
        idx++;
        if (idx == t.abort_at) begin
          rst = 1'b1;
          tick();
          chk_b("rst_out_valid", out_valid, 1'b0);
          chk_b("rst_core_rst", core_rst, 1'b1);
          chk_b("rst_busy", busy, 1'b0);
          chk_b("rst_in_ready", in_ready, 1'b0);
          chk_v("rst_out_data", 512'(out_data), 512'd0);
          rst = 1'b0;
          tick();
          chk_b("rst_in_ready_after", in_ready, 1'b1);
          out_ready = 1'b1;
          return;
        end
      end
    end
    out_ready = 1'b1;
    chk_b("drain_bound", guard < 400, 1'b1);
    chk_b("done_pulse", done, 1'b1);
    chk_b("end_in_ready", in_ready, 1'b1);
    chk_b("end_busy", busy, 1'b0);
    chk_b("end_valid", out_valid, 1'b0);
    chk_b("end_error", error, t.exp_err);
    tick();
    chk_b("done_clear", done, 1'b0);
  endtask

  initial begin
    logic [7:0][63:0] a_seq, a_ones;
    logic [4:0][63:0] k_fix, k_top;
    bit prev_err;
    int g;

    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1; stub_mode = M_OK;
    in_valid48 = 1'b0; in_data48 = '0; out_ready48 = 1'b0;
    repeat (3) tick();
    chk_b("rst_in_ready", in_ready, 1'b0);
    chk_b("rst_out_valid", out_valid, 1'b0);
    chk_b("rst_out_last", out_last, 1'b0);
    chk_b("rst_done", done, 1'b0);
    chk_b("rst_busy", busy, 1'b0);
    chk_b("rst_error", error, 1'b0);
    chk_b("rst_core_rst", core_rst, 1'b1);
    chk_v("rst_out_data", 512'(out_data), 512'd0);
    rst = 1'b0;
    tick();
    chk_b("post_rst_in_ready", in_ready, 1'b1);

    for (int w = 0; w < 8; w++) a_seq[w] = 64'(w + 1);
    a_ones = '1;
    k_fix  = rnd_k();
    k_top  = rnd_k();
    k_top[4] = 64'hFFFF_FFFF_FFFF_FFFF;

    tbl[0] = mk(M_OK,   1'b0, 0, a_seq,   k_fix);
    tbl[1] = mk(M_OK,   1'b1, 0, a_seq,   k_fix);
    tbl[2] = mk(M_OK,   1'b0, 0, rnd_a(), k_top);
    tbl[3] = mk(M_INV,  1'b1, 0, rnd_a(), rnd_k());
    tbl[4] = mk(M_OK,   1'b0, 0, rnd_a(), rnd_k());
    tbl[5] = mk(M_OK,   1'b0, 0, a_ones,  rnd_k());
    tbl[6] = mk(M_HANG, 1'b0, 0, rnd_a(), rnd_k());
    tbl[7] = mk(M_OK,   1'b0, 3, rnd_a(), rnd_k());
    tbl[8] = mk(M_OK,   1'b1, 0, rnd_a(), rnd_k());
    prev_err = 1'b0;
    for (int i = 0; i < 9; i++) begin
      tbl[i].err_before = prev_err;
      prev_err = (tbl[i].abort_at != 0) ? 1'b0 : tbl[i].exp_err;
    end
    for (int i = 0; i < 9; i++) run_txn(tbl[i]);

    // 48-bit bus: 11 A words and 7 key words of all ones; echo core.
    for (int w = 0; w < 18; w++) begin
      in_valid48 = 1'b1;
      in_data48  = '1;
      g = 0;
      while (!in_ready48 && g < 50) begin tick(); g++; end
      tick();
    end
    in_valid48 = 1'b0;
    chk_v("w48_core_A", core_A48, {512{1'b1}});
    chk_v("w48_core_key", 512'(core_key48), 512'({296{1'b1}}));
    g = 0;
    while (!out_valid48 && g < 100) begin tick(); g++; end
    chk_b("w48_valid_seen", out_valid48, 1'b1);
    out_ready48 = 1'b1;
    for (int w = 0; w < 11; w++) begin
      chk_v($sformatf("w48_word%0d", w), 512'(out_data48),
            (w == 10) ? 512'(48'h0000_FFFF_FFFF) : 512'(48'hFFFF_FFFF_FFFF));
      chk_b($sformatf("w48_last%0d", w), out_last48, w == 10);
      if (w == 10) chk_v("w48_pad", 512'(out_data48[47:32]), 512'd0);
      tick();
    end
    chk_b("w48_done", done48, 1'b1);
    chk_b("w48_error", error48, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
